// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-stage definitions for the store formatter and the
// load extender. It holds the access size encodings, the store FSM state
// type and a helper that gives the byte-lane mask for a size.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT1,
    ST_BEAT2,
    ST_RESP
  } state_e;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  // Lane mask for an access that starts at lane 0. The reserved size gives
  // 0, so it can never look like a crossing store.
  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] size);
    logic [BE_W-1:0] m;
    case (size_e'(size))
      SIZE_BYTE: m = 4'b0001;
      SIZE_HALF: m = 4'b0011;
      SIZE_WORD: m = 4'b1111;
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_formatter_if.sv
// store_formatter_if: request and bus signals of the store formatter.
//   req_*   : store request from the EX/MEM register (valid/ready)
//   bus_*   : aligned write beats to data memory (valid/ready)
//   done/err: one-cycle completion pulse and error flag
// The slave modport is the formatter side; master is the environment side.
interface store_formatter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_data;
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, bus_ready,
    output req_ready, bus_valid, bus_addr, bus_be, bus_data, done, err
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, bus_ready,
    input  req_ready, bus_valid, bus_addr, bus_be, bus_data, done, err
  );
endinterface

// File: rtl/store_formatter_lane_shifter.sv
// lane_shifter: combinational lane placement for a store.
//   data_i : register value, low bytes significant
//   k_i    : byte offset within the word (addr[1:0])
//   mask_i : lane mask of the access starting at lane 0
//   be1_o/data1_o : first (lower) word enables and data
//   be2_o/data2_o : second (next) word enables and data
//   cross_o       : access spills into the next word
// Data bytes in disabled lanes are forced to zero.
module lane_shifter
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        k_i,
  input  logic [BE_W-1:0]   mask_i,
  output logic [BE_W-1:0]   be1_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [BE_W-1:0]   be2_o,
  output logic [DATA_W-1:0] data2_o,
  output logic              cross_o
);

  logic [2*BE_W-1:0]   full;
  logic [2*DATA_W-1:0] wide;
  logic [DATA_W-1:0]   lane1;
  logic [DATA_W-1:0]   lane2;

  // One 64-bit shift yields both beats: the low half is data<<(8k), the high
  // half equals data>>(8*(4-k)).
  always_comb begin
    full = {{BE_W{1'b0}}, mask_i} << k_i;
    wide = {{DATA_W{1'b0}}, data_i} << {k_i, 3'b000};
    lane1 = '0;
    lane2 = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      lane1[8*i +: 8] = {8{full[i]}};
      lane2[8*i +: 8] = {8{full[BE_W+i]}};
    end
  end

  assign be1_o   = full[BE_W-1:0];
  assign be2_o   = full[2*BE_W-1:BE_W];
  assign data1_o = wide[DATA_W-1:0] & lane1;
  assign data2_o = wide[2*DATA_W-1:DATA_W] & lane2;
  assign cross_o = |full[2*BE_W-1:BE_W];

endmodule

// File: rtl/store_formatter.sv
// store_formatter: MEM-stage store path. Turns a register value plus store
// size into word-aligned bus beats with byte enables. Stores crossing a word
// boundary are split into two beats (SPLIT_EN=1) or rejected with err
// (SPLIT_EN=0). Reserved size is always rejected without a bus access.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   sif   : request/bus/done/err bundle (slave side)
module store_formatter
  import mem_pkg::*;
#(
  parameter int unsigned SPLIT_EN = 1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic clk,
  input  logic rst_n,
  store_formatter_if.slave sif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BE_W-1:0]   be2_q, be2_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic              cross_q, cross_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [BE_W-1:0]   mask;
  logic [BE_W-1:0]   sh_be1, sh_be2;
  logic [DATA_W-1:0] sh_data1, sh_data2;
  logic              sh_cross;
  logic              reject;

  assign mask = size_mask(sif.req_size);

  lane_shifter u_lane_shifter (
    .data_i  (sif.req_data),
    .k_i     (sif.req_addr[1:0]),
    .mask_i  (mask),
    .be1_o   (sh_be1),
    .data1_o (sh_data1),
    .be2_o   (sh_be2),
    .data2_o (sh_data2),
    .cross_o (sh_cross)
  );

  assign reject = (sif.req_size == SIZE_RSVD) || (sh_cross && (SPLIT_EN == 0));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
    be2_d   = be2_q;
    data2_d = data2_q;
    cross_d = cross_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sif.req_valid) begin
          if (reject) begin
            state_d = ST_RESP;
          end else begin
            addr_d  = {sif.req_addr[ADDR_W-1:2], 2'b00};
            be_d    = sh_be1;
            data_d  = sh_data1;
            be2_d   = sh_be2;
            data2_d = sh_data2;
            cross_d = sh_cross;
            state_d = ST_BEAT1;
          end
        end
      end
      ST_BEAT1: begin
        if (sif.bus_ready) begin
          if (cross_q) begin
            // Second beat loads straight into the bus registers, so
            // bus_valid stays high without a bubble.
            addr_d  = addr_q + ADDR_W'(4);
            be_d    = be2_q;
            data_d  = data2_q;
            state_d = ST_BEAT2;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_BEAT2: begin
        if (sif.bus_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      be2_q   <= '0;
      data2_q <= '0;
      cross_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
      be2_q   <= be2_d;
      data2_q <= data2_d;
      cross_q <= cross_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sif.req_ready = (state_q == ST_IDLE);
  assign sif.bus_valid = (state_q == ST_BEAT1) || (state_q == ST_BEAT2);
  assign sif.bus_addr  = addr_q;
  assign sif.bus_be    = be_q;
  assign sif.bus_data  = data_q;
  assign sif.done      = done_q;
  assign sif.err       = err_q;

endmodule

// File: tb/tb_store_formatter.sv
// Directed bench for store_formatter: DUT0 splits crossing stores, DUT1
// rejects them. Expected beats/responses for DUT0 go to a scoreboard that a
// negedge monitor drains; cycle-exact behaviour is checked inline.
module tb_store_formatter;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  beat_t beat_q[$];
  logic  resp_q[$];

  store_formatter_if #(.ADDR_W(32)) if0 ();
  store_formatter_if #(.ADDR_W(32)) if1 ();

  store_formatter #(.SPLIT_EN(1), .ADDR_W(32)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (if0.slave)
  );

  store_formatter #(.SPLIT_EN(0), .ADDR_W(32)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (if1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request to the selected DUT; returns 1 ns after the
  // accepting edge.
  task automatic send(input bit sel, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] data);
    logic rdy;
    rdy = sel ? if1.req_ready : if0.req_ready;
    for (int i = 0; i < 20 && !rdy; i++) begin
      tick();
      rdy = sel ? if1.req_ready : if0.req_ready;
    end
    if (!rdy) check("req_ready_timeout", 64'(rdy), 64'd1);
    if (sel) begin
      if1.req_addr = addr; if1.req_size = size; if1.req_data = data; if1.req_valid = 1'b1;
    end else begin
      if0.req_addr = addr; if0.req_size = size; if0.req_data = data; if0.req_valid = 1'b1;
    end
    tick();
    if0.req_valid = 1'b0;
    if1.req_valid = 1'b0;
  endtask

  // Scoreboard drain for DUT0.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (if0.bus_valid && if0.bus_ready) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 64'(if0.bus_be), 64'd0);
        end else begin
          beat_t b;
          logic [31:0] m;
          b = beat_q.pop_front();
          m = lanes(b.be);
          check("sb_addr", 64'(if0.bus_addr), 64'(b.addr));
          check("sb_be", 64'(if0.bus_be), 64'(b.be));
          check("sb_data", 64'(if0.bus_data & m), 64'(b.data & m));
        end
      end
      if (if0.done) begin
        if (resp_q.size() == 0) begin
          check("done_unexpected", 64'(if0.done), 64'd0);
        end else begin
          logic e;
          e = resp_q.pop_front();
          check("sb_err", 64'(if0.err), 64'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_be;

    rst_n = 1'b0;
    if0.req_valid = 1'b0; if0.req_addr = '0; if0.req_data = '0; if0.req_size = '0;
    if1.req_valid = 1'b0; if1.req_addr = '0; if1.req_data = '0; if1.req_size = '0;
    if0.bus_ready = 1'b1;
    if1.bus_ready = 1'b1;

    // Reset state
    #3;
    check("rst_req_ready", 64'(if0.req_ready), 64'd1);
    check("rst_bus_valid", 64'(if0.bus_valid), 64'd0);
    check("rst_bus_addr", 64'(if0.bus_addr), 64'd0);
    check("rst_bus_be", 64'(if0.bus_be), 64'd0);
    check("rst_bus_data", 64'(if0.bus_data), 64'd0);
    check("rst_done_err", 64'({if0.done, if0.err}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Byte store at lane 2
    beat_q.push_back('{32'h0000_1000, 4'b0100, 32'h00DD_0000});
    resp_q.push_back(1'b0);
    send(0, 32'h0000_1002, 2'b00, 32'hAABB_CCDD);
    check("byte_valid", 64'(if0.bus_valid), 64'd1);
    check("byte_ready_low", 64'(if0.req_ready), 64'd0);
    check("byte_addr", 64'(if0.bus_addr), 64'h1000);
    check("byte_be", 64'(if0.bus_be), 64'b0100);
    check("byte_lane2", 64'(if0.bus_data[23:16]), 64'hDD);
    tick();
    check("byte_done", 64'({if0.done, if0.err}), 64'b10);
    check("byte_ready_back", 64'(if0.req_ready), 64'd1);
    check("byte_valid_off", 64'(if0.bus_valid), 64'd0);

    // Aligned word, bus_ready low for three cycles
    if0.bus_ready = 1'b0;
    beat_q.push_back('{32'h0000_2000, 4'b1111, 32'h1234_5678});
    resp_q.push_back(1'b0);
    send(0, 32'h0000_2000, 2'b10, 32'h1234_5678);
    s_addr = if0.bus_addr; s_be = if0.bus_be; s_data = if0.bus_data;
    check("bp_be", 64'(s_be), 64'b1111);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 64'(if0.bus_valid), 64'd1);
      check("bp_stable", 64'({if0.bus_addr, if0.bus_be, if0.bus_data}), 64'({s_addr, s_be, s_data}));
      check("bp_no_done", 64'(if0.done), 64'd0);
      tick();
    end
    if0.bus_ready = 1'b1;
    check("bp_valid4", 64'(if0.bus_valid), 64'd1);
    check("bp_stable4", 64'({if0.bus_addr, if0.bus_be, if0.bus_data}), 64'({s_addr, s_be, s_data}));
    tick();
    check("bp_done", 64'(if0.done), 64'd1);
    tick();
    check("bp_done_once", 64'(if0.done), 64'd0);

    // Crossing half at offset 3
    beat_q.push_back('{32'h0000_0000, 4'b1000, 32'hEF00_0000});
    beat_q.push_back('{32'h0000_0004, 4'b0001, 32'h0000_00BE});
    resp_q.push_back(1'b0);
    send(0, 32'h0000_0003, 2'b01, 32'h0000_BEEF);
    check("xh_b1_be", 64'(if0.bus_be), 64'b1000);
    check("xh_b1_lane3", 64'(if0.bus_data[31:24]), 64'hEF);
    tick();
    check("xh_b2_valid", 64'(if0.bus_valid), 64'd1);
    check("xh_b2_addr", 64'(if0.bus_addr), 64'h4);
    check("xh_b2_lane0", 64'(if0.bus_data[7:0]), 64'hBE);
    check("xh_no_early_done", 64'(if0.done), 64'd0);
    tick();
    check("xh_done", 64'({if0.done, if0.err}), 64'b10);

    // Crossing word with address wrap
    beat_q.push_back('{32'hFFFF_FFFC, 4'b1100, 32'h3344_0000});
    beat_q.push_back('{32'h0000_0000, 4'b0011, 32'h0000_1122});
    resp_q.push_back(1'b0);
    send(0, 32'hFFFF_FFFE, 2'b10, 32'h1122_3344);
    check("wrap_b1_addr", 64'(if0.bus_addr), 64'hFFFF_FFFC);
    tick();
    check("wrap_b2_addr", 64'(if0.bus_addr), 64'h0);
    check("wrap_b2_be", 64'(if0.bus_be), 64'b0011);
    tick();
    check("wrap_done", 64'(if0.done), 64'd1);

    // Aligned half in the upper lanes
    beat_q.push_back('{32'h0000_0010, 4'b1100, 32'hABCD_0000});
    resp_q.push_back(1'b0);
    send(0, 32'h0000_0012, 2'b01, 32'h1234_ABCD);
    tick();
    check("hi_half_done", 64'(if0.done), 64'd1);

    // Reserved size
    resp_q.push_back(1'b1);
    send(0, 32'h0000_0040, 2'b11, 32'hDEAD_BEEF);
    check("rsvd_no_valid", 64'(if0.bus_valid), 64'd0);
    check("rsvd_no_early_done", 64'(if0.done), 64'd0);
    tick();
    check("rsvd_resp", 64'({if0.done, if0.err, if0.bus_valid}), 64'b110);

    // SPLIT_EN=0: crossing word rejected, non-crossing half accepted
    send(1, 32'h0000_0001, 2'b10, 32'hCAFE_F00D);
    check("nosplit_no_valid", 64'(if1.bus_valid), 64'd0);
    tick();
    check("nosplit_err", 64'({if1.done, if1.err, if1.bus_valid}), 64'b110);
    send(1, 32'h0000_0005, 2'b01, 32'h0000_CAFE);
    check("ns_half_valid", 64'(if1.bus_valid), 64'd1);
    check("ns_half_addr", 64'(if1.bus_addr), 64'h4);
    check("ns_half_be", 64'(if1.bus_be), 64'b0110);
    check("ns_half_data", 64'(if1.bus_data & 32'h00FF_FF00), 64'h00CA_FE00);
    tick();
    check("ns_half_done", 64'({if1.done, if1.err}), 64'b10);

    // Asynchronous reset while in BEAT2
    if0.bus_ready = 1'b0;
    beat_q.push_back('{32'h0000_0100, 4'b1000, 32'hCD00_0000});
    send(0, 32'h0000_0103, 2'b01, 32'h0000_ABCD);
    if0.bus_ready = 1'b1;
    tick();
    if0.bus_ready = 1'b0;
    check("rstmid_in_beat2", 64'({if0.bus_valid, if0.bus_be}), 64'b1_0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid_drop", 64'(if0.bus_valid), 64'd0);
    check("rstmid_be_clear", 64'(if0.bus_be), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rstmid_ready", 64'(if0.req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_no_done", 64'({if0.done, if0.bus_valid}), 64'd0);
    end
    if0.bus_ready = 1'b1;

    check("sb_beats_left", 64'(beat_q.size()), 64'd0);
    check("sb_resps_left", 64'(resp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/store_formatter.md
Name: store_formatter

Overview:
- MEM-stage store path. It is the narrowing counterpart of the immediate/load extender: it takes a 32-bit register value and a store size, and produces byte-lane-aligned data plus byte enables for the data bus.
- Misaligned halfword/word stores that cross a word boundary are split into two aligned bus beats by a small FSM.
- Sits between the EX/MEM pipeline register (upstream valid/ready) and the data-memory write port (downstream valid/ready).

Parameters:
- SPLIT_EN, 1, 1 = split word-crossing stores into two beats; 0 = flag them as errors with no bus access
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  byte address
- req_data  in  32  register value to store; low bytes are significant for byte/half
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- bus_valid  out  1  bus write beat valid
- bus_ready  in  1  memory accepts the beat
- bus_addr  out  ADDR_W  word-aligned address, low 2 bits always 0
- bus_be  out  4  byte enables, bit i = byte lane i (little-endian)
- bus_data  out  32  lane-shifted write data
- done  out  1  one-cycle pulse when the request completes
- err  out  1  one-cycle pulse with done on a reserved size or, when SPLIT_EN=0, a misaligned crossing store

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, req_ready=1, bus_valid=0, bus_addr=0, bus_be=0, bus_data=0, done=0, err=0. Assertion mid-transaction abandons the request with no done.
- Size and offset definitions:
  - nbytes: byte=1, half=2, word=4.
  - k = req_addr[1:0].
  - mask = (1<<nbytes)-1.
  - full = mask<<k, 8 bits.
  - Crossing when full[7:4] != 0.
- FSM states: IDLE, BEAT1, BEAT2, RESP.
- IDLE
  - req_ready=1; a request is accepted when req_valid & req_ready.
  - Accepted reserved size: go to RESP with err=1.
  - Accepted crossing store with SPLIT_EN=0: go to RESP with err=1.
  - Otherwise register the beat fields and go to BEAT1.
    - Beat-1 fields: bus_addr={addr[W-1:2],2'b00}, bus_be=full[3:0], bus_data=req_data<<(8k).
    - For a crossing store, also latch the beat-2 fields: be2=full[7:4], data2=req_data>>(8*(4-k)).
- BEAT1
  - bus_valid=1 from the cycle after acceptance (latency 1).
  - bus_* stay stable while bus_ready=0.
  - On bus_ready, non-crossing: done pulses next cycle, go to IDLE.
  - On bus_ready, crossing: bus_addr+=4 (modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0), bus_be=be2, bus_data=data2, go to BEAT2; bus_valid stays high with no bubble.
- BEAT2: on bus_ready, done pulses, go to IDLE.
- RESP: done=1 and err as latched, bus_valid=0, go to IDLE. No bus access occurs.
- done/err timing: both are registered and pulse exactly one cycle, in the cycle after the final handshake. req_ready returns to 1 in that same cycle, so back-to-back throughput is one request per 2 cycles for aligned stores.
- Bytes in disabled lanes of bus_data are don't-care for verification; the implementation drives 0.
- req_ready is low outside IDLE. req_* inputs are ignored while req_ready=0.

Decomposition:
- Shared package mem_pkg:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD encodings, shared with the load extender.
  - State enum.
  - Function size_mask(size) returning the 4-bit mask.
- Sub-module lane_shifter: combinational; inputs data, k, mask; outputs the beat-1 and beat-2 be/data pairs. The FSM and handshake registers live in store_formatter.

Test Plan:
- Byte store: addr=0x1002, size=00, data=0xAABBCCDD, bus_ready=1 → one beat at cycle+1, addr=0x1000, be=0100, data lane2=0xDD; done at cycle+2, err=0.
- Aligned word with backpressure: addr=0x2000, data=0x12345678, bus_ready low 3 cycles → bus_* stable for 4 cycles with be=1111; single done after the handshake.
- Crossing half, SPLIT_EN=1: addr=0x0003, data=0x0000BEEF →
  - beat1: addr=0x0000, be=1000, lane3=0xEF;
  - beat2: addr=0x0004, be=0001, lane0=0xBE;
  - then done.
- Crossing word with wrap: addr=0xFFFFFFFE, data=0x11223344 →
  - beat1: 0xFFFFFFFC, be=1100, data[31:16]=0x3344;
  - beat2: 0x00000000, be=0011, data[15:0]=0x1122.
- Errors: size=11 → no bus_valid, done=err=1 at cycle+2. With SPLIT_EN=0, addr=0x1 and size=10 → same error response.
- Reset mid-BEAT2: drop rst_n asynchronously → bus_valid=0 immediately, req_ready=1 after release, no done pulse.
